d_write_buffer: RTL and testbench

Write-through buffer between the data cache's memory-side port and the data memory bus. It absorbs the cache's write-through stores into a small FIFO and acknowledges them in the same cycle when space exists, then drains them to memory one at a time. Read misses are held until every buffered store has reached memory, then issued directly to memory. This keeps the CPU from stalling on every store while read-after-write order stays exact.

---
 rtl/d_write_buffer.sv | 125 ++++++++++++
 tb/tb_d_write_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/d_write_buffer.sv
// Write-through store buffer between the data cache and the memory bus.
// Stores are acknowledged into a small FIFO and drained one at a time; reads wait until the FIFO is empty.
module d_write_buffer #(
  parameter int A_WIDTH    = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] c_a,
  input  logic [31:0]        c_din,
  input  logic [3:0]         c_wen,
  input  logic               c_strobe,
  input  logic               c_rw,
  output logic [31:0]        c_dout,
  output logic               c_ready,
  output logic [A_WIDTH-1:0] mem_a,
  output logic [31:0]        mem_wdata,
  output logic [3:0]         mem_wen,
  output logic               mem_strobe,
  output logic               mem_rw,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_ready,
  output logic               buf_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t state, state_next;

  logic [A_WIDTH-1:0]    fifo_a [DEPTH];
  logic [31:0]           fifo_d [DEPTH];
  logic [3:0]            fifo_w [DEPTH];
  logic [DEPTH_LOG2-1:0] head, tail;
  logic [DEPTH_LOG2:0]   count;
  logic                  full, push, pop;
  logic                  load_wr, load_rd, done;

  // full comes from the registered count, so a same-cycle pop never frees a slot for a push
  assign full      = (count == DEPTH_CNT);
  assign push      = c_strobe & c_rw & ~full;
  assign pop       = (state == WRITE) & mem_ready;
  assign c_ready   = push | ((state == READ) & mem_ready);
  assign c_dout    = ((state == READ) & mem_ready) ? mem_rdata : 32'h0;
  assign buf_empty = (count == '0) & (state != WRITE);

  always_comb begin
    state_next = state;
    load_wr    = 1'b0;
    load_rd    = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          load_wr    = 1'b1;
          state_next = WRITE;
        end else if (c_strobe & ~c_rw) begin
          load_rd    = 1'b1;
          state_next = READ;
        end
      end
      WRITE, READ: begin
        if (mem_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      mem_a      <= '0;
      mem_wdata  <= '0;
      mem_wen    <= '0;
      mem_strobe <= 1'b0;
      mem_rw     <= 1'b0;
    end else begin
      state <= state_next;
      if (load_wr) begin
        mem_a      <= fifo_a[head];
        mem_wdata  <= fifo_d[head];
        mem_wen    <= fifo_w[head];
        mem_rw     <= 1'b1;
        mem_strobe <= 1'b1;
      end else if (load_rd) begin
        mem_a      <= c_a;
        mem_wen    <= 4'b0000;
        mem_rw     <= 1'b0;
        mem_strobe <= 1'b1;
      end else if (done) begin
        mem_strobe <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[tail] <= c_a;
      fifo_d[tail] <= c_din;
      fifo_w[tail] <= c_wen;
    end
  end

endmodule

// File: tb/tb_d_write_buffer.sv
// Bench for d_write_buffer: directed scenarios plus random cache/memory traffic
// checked against a queue model of accepted-but-not-yet-written stores.
module tb_d_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] c_a, c_din, c_dout, mem_a, mem_wdata, mem_rdata;
  logic [3:0]  c_wen, mem_wen;
  logic        c_strobe, c_rw, c_ready, mem_strobe, mem_rw, mem_ready, buf_empty;

  d_write_buffer #(.A_WIDTH(32), .DEPTH_LOG2(2)) dut (
    .clk(clk), .clrn(clrn),
    .c_a(c_a), .c_din(c_din), .c_wen(c_wen), .c_strobe(c_strobe), .c_rw(c_rw),
    .c_dout(c_dout), .c_ready(c_ready),
    .mem_a(mem_a), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_strobe(mem_strobe), .mem_rw(mem_rw),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  w;
  } store_t;

  store_t      q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          age = 0;
  int          writes_done = 0;
  logic        prev_busy = 1'b0;
  logic [31:0] prev_a, prev_d;
  logic [3:0]  prev_w;
  logic        prev_rw;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Called at the negedge with inputs stable: predicts and compares, then advances the model.
  task automatic observe();
    store_t s;
    logic   room;
    room = (q.size() < DEPTH);
    check("buf_empty", 32'(buf_empty), 32'(q.size() == 0));
    if (c_strobe && c_rw)
      check("wr_ack", 32'(c_ready), 32'(room));
    else if (c_strobe && !c_rw)
      check("rd_ack", 32'(c_ready), 32'(mem_strobe && !mem_rw && mem_ready));
    else
      check("no_req_ack", 32'(c_ready), 32'(mem_strobe && !mem_rw && mem_ready));
    check("c_dout", c_dout, (mem_strobe && !mem_rw && mem_ready) ? mem_rdata : 32'h0);
    if (prev_busy) begin
      check("hold_strobe", 32'(mem_strobe), 32'h1);
      check("hold_a", mem_a, prev_a);
      check("hold_rw", 32'(mem_rw), 32'(prev_rw));
      check("hold_w", 32'(mem_wen), 32'(prev_w));
      if (prev_rw) check("hold_d", mem_wdata, prev_d);
    end
    if (mem_strobe && !mem_rw) begin
      check("rd_after_writes", 32'(q.size()), 32'h0);
      check("rd_addr", mem_a, c_a);
      check("rd_wen", 32'(mem_wen), 32'h0);
    end
    if (mem_strobe && mem_rw && mem_ready) begin
      check("wr_has_entry", 32'(q.size() != 0), 32'h1);
      if (q.size() != 0) begin
        s = q.pop_front();
        check("wr_addr", mem_a, s.a);
        check("wr_data", mem_wdata, s.d);
        check("wr_wen", 32'(mem_wen), 32'(s.w));
        writes_done++;
      end
    end
    if (c_strobe && c_rw && room) begin
      s.a = c_a; s.d = c_din; s.w = c_wen;
      q.push_back(s);
    end
    if (mem_strobe && mem_ready) age = 0;
    else if (mem_strobe) age++;
    prev_busy = mem_strobe && !mem_ready;
    prev_a = mem_a; prev_d = mem_wdata; prev_w = mem_wen; prev_rw = mem_rw;
  endtask

  // lat<0: mem_ready always 1; lat==0: held 0; lat>0: ready on the lat-th strobe cycle.
  task automatic drive(input logic s, input logic rw, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] w, input int lat);
    @(posedge clk); #1;
    c_strobe = s; c_rw = rw; c_a = a; c_din = d; c_wen = w;
    if (lat < 0)        mem_ready = 1'b1;
    else if (lat == 0)  mem_ready = 1'b0;
    else if (mem_strobe) mem_ready = (age + 1 >= lat);
    else                mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom();
    @(negedge clk);
    observe();
  endtask

  task automatic drain(input int lat);
    int n;
    n = 0;
    while (!(buf_empty && !mem_strobe) && n < 60) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, lat);
      n++;
    end
    check("drain_done", 32'(buf_empty && !mem_strobe), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rise, fin, base, k, n;
    logic        act, r_rw;
    logic [31:0] r_a, r_d, d4;
    logic [3:0]  r_w;

    clrn = 1'b0; c_strobe = 1'b0; c_rw = 1'b0; c_a = '0; c_din = '0; c_wen = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    #2;
    check("rst_strobe", 32'(mem_strobe), 32'h0);
    check("rst_rw", 32'(mem_rw), 32'h0);
    check("rst_a", mem_a, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_wen", 32'(mem_wen), 32'h0);
    check("rst_empty", 32'(buf_empty), 32'h1);
    @(negedge clk); clrn = 1'b1;

    // single store
    drive(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, -1);
    check("st_ack", 32'(c_ready), 32'h1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, -1);
    check("st_not_empty", 32'(buf_empty), 32'h0);
    check("st_strobe_late", 32'(mem_strobe), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, -1);
    check("st_strobe", 32'(mem_strobe), 32'h1);
    check("st_rw", 32'(mem_rw), 32'h1);
    check("st_a", mem_a, 32'h100);
    check("st_d", mem_wdata, 32'hDEADBEEF);
    check("st_w", 32'(mem_wen), 32'hF);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, -1);
    check("st_empty_after", 32'(buf_empty), 32'h1);

    // fill to full, fifth store stalls until a pop has registered
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h300 + 32'(4 * i), $urandom(), 4'hF, 0);
      check("fill_ack", 32'(c_ready), 32'h1);
    end
    d4 = $urandom();
    drive(1'b1, 1'b1, 32'h310, d4, 4'h5, 0);
    check("full_nack", 32'(c_ready), 32'h0);
    drive(1'b1, 1'b1, 32'h310, d4, 4'h5, -1);
    check("full_pop_nack", 32'(c_ready), 32'h0);
    drive(1'b1, 1'b1, 32'h310, d4, 4'h5, 0);
    check("full_retry_ack", 32'(c_ready), 32'h1);
    drain(2);

    // store then read of the same address with 3-cycle memory latency
    drive(1'b1, 1'b1, 32'h200, 32'h11223344, 4'b0011, 3);
    check("raw_st_ack", 32'(c_ready), 32'h1);
    rise = -1; fin = -1;
    for (int i = 0; i < 40 && fin < 0; i++) begin
      drive(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 3);
      if (rise < 0 && mem_strobe && !mem_rw) rise = i;
      if (c_ready) fin = i;
    end
    check("raw_rd_done", 32'(fin >= 0), 32'h1);
    check("raw_rd_latency", 32'(fin - rise), 32'h2);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3);

    // reset in the middle of a write
    drive(1'b1, 1'b1, 32'h500, 32'hCAFEF00D, 4'hF, 0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    check("rst_mid_pre", 32'(mem_strobe), 32'h1);
    @(posedge clk); #3;
    clrn = 1'b0;
    #1;
    check("rst_mid_strobe", 32'(mem_strobe), 32'h0);
    check("rst_mid_empty", 32'(buf_empty), 32'h1);
    @(negedge clk); clrn = 1'b1;
    q.delete(); age = 0; prev_busy = 1'b0;
    drive(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1);
    drive(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1);
    check("rst_rd_strobe", 32'(mem_strobe), 32'h1);
    check("rst_rd_a", mem_a, 32'h40);
    check("rst_rd_ready", 32'(c_ready), 32'h1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1);

    // ten stores with random gaps across a pointer wrap
    base = writes_done; k = 0; n = 0; act = 1'b0;
    r_a = '0; r_d = '0; r_w = '0;
    while (k < 10 && n < 300) begin
      if (!act && $urandom_range(0, 1) == 1) begin
        act = 1'b1;
        r_a = 32'h1000 + 32'(k * 4); r_d = $urandom(); r_w = 4'($urandom_range(1, 15));
      end
      drive(act, 1'b1, r_a, r_d, r_w, -1);
      if (act && c_ready) begin act = 1'b0; k++; end
      n++;
    end
    check("wrap_accepted", 32'(k), 32'd10);
    drain(-1);
    check("wrap_written", 32'(writes_done - base), 32'd10);

    // random mixed traffic with random memory latency
    act = 1'b0; r_rw = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!act && $urandom_range(0, 9) > 2) begin
        act  = 1'b1;
        r_rw = ($urandom_range(0, 9) > 2);
        r_a  = {$urandom_range(0, 255), 2'b00};
        r_d  = $urandom();
        r_w  = r_rw ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      drive(act, r_rw, r_a, r_d, r_w, int'($urandom_range(1, 4)));
      if (act && c_ready) act = 1'b0;
    end
    drain(2);
    check("rand_model_empty", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
